// File: rtl/bg_pkg.sv
// Shared types and constants for the background fetch arbiter: FSM states,
// pixel nibble offsets, default FIFO depth and the posted-write record.
package bg_pkg;
  localparam int BG_FIFO_DEPTH = 4;
  localparam int PIX_W     = 16;
  localparam int PIX_R_LSB = 0;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_LSB = 8;
  localparam int PIX_A_LSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } bg_state_e;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
  } bg_wr_t;

  function automatic logic [PIX_W-1:0] pix_sel(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction
endpackage

// File: rtl/bg_word_fifo.sv
// 32-bit word FIFO holding prefetched background data; flush wins over push/pop.
module bg_word_fifo
  import bg_pkg::*;
#(
  parameter int DEPTH = BG_FIFO_DEPTH
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [31:0]              din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic        do_push, do_pop;

  assign level   = wp_q - rp_q;
  assign empty   = (level == '0);
  assign full    = level[AW];
  assign dout    = mem_q[rp_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bg_fetch_arbiter.sv
// Shares one SDRAM channel between overlay download writes and background
// prefetch reads, and streams the prefetched words out as 16-bit pixels.
module bg_fetch_arbiter
  import bg_pkg::*;
#(
  parameter int FIFO_DEPTH = BG_FIFO_DEPTH
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        rom_dl,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  input  logic        sdram_ok,
  input  logic        ce_pix,
  input  logic        vsync,
  input  logic        de,
  output logic [15:0] pix_rgba,
  output logic        bg_valid,
  output logic        underrun,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_req,
  output logic        mem_rnw,
  input  logic        mem_ack,
  input  logic [31:0] mem_dout
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  bg_state_e   state_q;
  logic        mem_req_q, mem_rnw_q;
  logic [23:0] mem_addr_q;
  logic [15:0] mem_din_q;

  logic [7:0]  lo_q, lo_d;
  logic        pend_q, pend_d, hold_q, hold_d;
  bg_wr_t      pend_wr_q, pend_wr_d, hold_wr_q, hold_wr_d, new_wr;
  logic        bg_valid_q, bg_valid_d, dl_act_q, vs_q;
  logic        rd_drop_q, rd_drop_d, half_q, half_d, underrun_q, underrun_d;
  logic [23:0] fa_q, fa_d;
  logic [15:0] pix_q, pix_d;

  logic          odd_wr, wr_ack, rd_ack, vs_rise, active, pix_evt;
  logic          fifo_push, fifo_pop, rd_go;
  logic [31:0]   fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  assign odd_wr    = dl_wr && dl_addr[0];
  assign new_wr    = '{addr: dl_addr[24:1], data: {dl_data, lo_q}};
  assign wr_ack    = (state_q == ST_WR) && mem_ack;
  assign rd_ack    = (state_q == ST_RD) && mem_ack;
  assign vs_rise   = vsync && !vs_q;
  assign active    = bg_valid_q && !dl_active;
  assign pix_evt   = active && ce_pix && de && !vs_rise;
  assign fifo_push = rd_ack && !rd_drop_q && !vs_rise && !fifo_full;
  assign fifo_pop  = pix_evt && half_q && !fifo_empty;
  assign rd_go     = active && !vs_rise && (fifo_level < DEPTH_L);

  bg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (mem_dout),
    .pop     (fifo_pop),
    .flush   (vs_rise),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Posted write plus one overflow slot; the overflow slot is what raises dl_wait.
  always_comb begin
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hold_d    = hold_q;
    hold_wr_d = hold_wr_q;
    if (dl_wr && !dl_addr[0]) lo_d = dl_data;
    if (wr_ack) begin
      pend_d    = hold_q;
      pend_wr_d = hold_wr_q;
      hold_d    = 1'b0;
      if (odd_wr) begin
        if (hold_q) begin
          hold_d    = 1'b1;
          hold_wr_d = new_wr;
        end else begin
          pend_d    = 1'b1;
          pend_wr_d = new_wr;
        end
      end
    end else if (odd_wr) begin
      if (!pend_q) begin
        pend_d    = 1'b1;
        pend_wr_d = new_wr;
      end else begin
        hold_d    = 1'b1;
        hold_wr_d = new_wr;
      end
    end
  end

  always_comb begin
    pix_d      = pix_q;
    half_d     = half_q;
    underrun_d = underrun_q;
    if (!active) begin
      pix_d = '0;
    end else if (pix_evt) begin
      if (fifo_empty) begin
        pix_d      = '0;
        underrun_d = 1'b1;
      end else begin
        pix_d  = pix_sel(fifo_dout, half_q);
        half_d = !half_q;
      end
    end
    if (vs_rise) half_d = 1'b0;
  end

  // A read caught in flight by a frame restart is tagged so its data is dropped.
  always_comb begin
    fa_d = fa_q;
    if (vs_rise)        fa_d = '0;
    else if (fifo_push) fa_d = fa_q + 24'd2;
    rd_drop_d = rd_drop_q;
    if (rd_ack)                             rd_drop_d = 1'b0;
    else if (vs_rise && state_q == ST_RD)   rd_drop_d = 1'b1;
    bg_valid_d = bg_valid_q;
    if (rom_dl)                                     bg_valid_d = 1'b0;
    else if (dl_active && !dl_act_q && sdram_ok)    bg_valid_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lo_q       <= '0;
      pend_q     <= 1'b0;
      pend_wr_q  <= '0;
      hold_q     <= 1'b0;
      hold_wr_q  <= '0;
      bg_valid_q <= 1'b0;
      dl_act_q   <= 1'b0;
      vs_q       <= 1'b0;
      rd_drop_q  <= 1'b0;
      half_q     <= 1'b0;
      underrun_q <= 1'b0;
      fa_q       <= '0;
      pix_q      <= '0;
    end else begin
      lo_q       <= lo_d;
      pend_q     <= pend_d;
      pend_wr_q  <= pend_wr_d;
      hold_q     <= hold_d;
      hold_wr_q  <= hold_wr_d;
      bg_valid_q <= bg_valid_d;
      dl_act_q   <= dl_active;
      vs_q       <= vsync;
      rd_drop_q  <= rd_drop_d;
      half_q     <= half_d;
      underrun_q <= underrun_d;
      fa_q       <= fa_d;
      pix_q      <= pix_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_rnw_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            state_q    <= ST_WR;
            mem_req_q  <= 1'b1;
            mem_rnw_q  <= 1'b0;
            mem_addr_q <= pend_wr_q.addr;
            mem_din_q  <= pend_wr_q.data;
          end else if (rd_go) begin
            state_q    <= ST_RD;
            mem_req_q  <= 1'b1;
            mem_rnw_q  <= 1'b1;
            mem_addr_q <= fa_q;
          end
        end
        ST_WR, ST_RD: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_rnw_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_rnw  = mem_rnw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign dl_wait  = hold_q;
  assign bg_valid = bg_valid_q;
  assign underrun = underrun_q;
  // Output nibble placement is {a,b,g,r}.
  assign pix_rgba = {pix_q[PIX_A_LSB +: 4], pix_q[PIX_B_LSB +: 4],
                     pix_q[PIX_G_LSB +: 4], pix_q[PIX_R_LSB +: 4]};
endmodule

// File: tb/tb_bg_fetch_arbiter.sv
// Directed + randomized bench for bg_fetch_arbiter with an SDRAM responder
// and a word-image reference model of the downloaded background.
module tb_bg_fetch_arbiter;
  logic        clk_sys, reset_n, dl_active, rom_dl, dl_wr, dl_wait, sdram_ok;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        ce_pix, vsync, de, bg_valid, underrun;
  logic [15:0] pix_rgba, mem_din;
  logic [23:0] mem_addr;
  logic        mem_req, mem_rnw, mem_ack;
  logic [31:0] mem_dout;

  bg_fetch_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .rom_dl(rom_dl),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .sdram_ok(sdram_ok), .ce_pix(ce_pix), .vsync(vsync), .de(de),
    .pix_rgba(pix_rgba), .bg_valid(bg_valid), .underrun(underrun),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_req(mem_req), .mem_rnw(mem_rnw),
    .mem_ack(mem_ack), .mem_dout(mem_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [23:0] a; logic [15:0] d; } wr_t;

  int          n_tests = 0, n_fail = 0;
  int          ack_delay = 0, wcnt = 0, wchk = 0, p = 0;
  bit          ack_stall = 0, inject_ack = 0;
  logic [15:0] img [256];
  logic [15:0] ref_img [256];
  logic [7:0]  m_lo = 8'h00;
  logic [7:0]  rsp_ai;
  wr_t         wlog[$];
  wr_t         wexp[$];

  // SDRAM responder: acks ack_delay cycles after a request is seen.
  initial begin
    mem_ack = 1'b0;
    mem_dout = '0;
    for (int i = 0; i < 256; i++) img[i] = 16'h0;
    forever begin
      @(posedge clk_sys); #1;
      mem_ack = 1'b0;
      if (inject_ack) begin
        mem_ack = 1'b1;
        inject_ack = 0;
      end else if (!mem_req || !reset_n) begin
        wcnt = 0;
      end else if (!ack_stall) begin
        if (wcnt >= ack_delay) begin
          wcnt = 0;
          mem_ack = 1'b1;
          rsp_ai = mem_addr[7:0];
          if (mem_rnw) mem_dout = {img[rsp_ai + 8'd1], img[rsp_ai]};
          else begin
            img[rsp_ai] = mem_din;
            wlog.push_back('{mem_addr, mem_din});
          end
        end else wcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (dl_wait && n < 300) begin tick(); n++; end
    if (n >= 300) chk("dl_wait_stuck", 32'(dl_wait), 32'd0);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
    if (!a[0]) m_lo = d;
    else begin
      wexp.push_back('{a[24:1], {d, m_lo}});
      ref_img[a[8:1]] = {d, m_lo};
    end
  endtask

  task automatic send_word(input logic [23:0] wa, input logic [15:0] d);
    send_byte({wa, 1'b0}, d[7:0]);
    send_byte({wa, 1'b1}, d[15:8]);
  endtask

  task automatic wait_writes();
    int n = 0;
    while (wlog.size() < wexp.size() && n < 3000) begin tick(); n++; end
    chk("wr_count", 32'(wlog.size()), 32'(wexp.size()));
    while (wchk < wexp.size() && wchk < wlog.size()) begin
      chk($sformatf("wr%0d_addr", wchk), 32'(wlog[wchk].a), 32'(wexp[wchk].a));
      chk($sformatf("wr%0d_data", wchk), 32'(wlog[wchk].d), 32'(wexp[wchk].d));
      wchk++;
    end
  endtask

  task automatic pop_check(input int n);
    for (int i = 0; i < n; i++) begin
      ce_pix = 1'b1; de = 1'b1;
      tick();
      chk($sformatf("pix%0d", p), 32'(pix_rgba), 32'(ref_img[p[7:0]]));
      p++;
    end
    ce_pix = 1'b0; de = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_mem_req"},  32'(mem_req),  32'd0);
    chk({pfx, "_mem_rnw"},  32'(mem_rnw),  32'd1);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({pfx, "_mem_din"},  32'(mem_din),  32'd0);
    chk({pfx, "_dl_wait"},  32'(dl_wait),  32'd0);
    chk({pfx, "_pix"},      32'(pix_rgba), 32'd0);
    chk({pfx, "_bg_valid"}, 32'(bg_valid), 32'd0);
    chk({pfx, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) ref_img[i] = 16'h0;
    reset_n = 1'b0; dl_active = 1'b0; rom_dl = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0; sdram_ok = 1'b1; ce_pix = 1'b0; vsync = 1'b0; de = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    // Single write: bytes 0x34@0, 0x12@1
    dl_active = 1'b1; ack_delay = 3;
    tick();
    chk("bg_valid_set", 32'(bg_valid), 32'd1);
    send_word(24'd0, 16'h1234);
    n = 0;
    while (!mem_req && n < 50) begin tick(); n++; end
    chk("w0_req", 32'(mem_req), 32'd1);
    chk("w0_addr", 32'(mem_addr), 32'd0);
    chk("w0_din", 32'(mem_din), 32'h1234);
    chk("w0_rnw", 32'(mem_rnw), 32'd0);
    wait_writes();

    // Slow acks: each odd strobe behind a pending write raises dl_wait
    ack_delay = 10;
    send_word(24'd0, 16'hAAAA);
    send_word(24'd1, 16'hBBBB);
    chk("dl_wait_w1", 32'(dl_wait), 32'd1);
    send_word(24'd2, 16'hCCCC);
    chk("dl_wait_w2", 32'(dl_wait), 32'd1);
    send_word(24'd3, 16'hDDDD);
    chk("dl_wait_w3", 32'(dl_wait), 32'd1);
    wait_writes();
    chk("dl_wait_clear", 32'(dl_wait), 32'd0);

    // Random background words 4..31 with random ack latency
    for (int w = 4; w < 32; w++) begin
      ack_delay = $urandom_range(0, 3);
      send_word(24'(w), 16'($urandom));
    end
    wait_writes();

    // Pixel stream with sparse pops
    dl_active = 1'b0; ack_delay = 2;
    repeat (30) tick();
    p = 0;
    for (int c = 0; c < 1500 && p < 24; c++) begin
      ce_pix = (c % 4 == 0);
      de = ($urandom_range(0, 3) != 0);
      tick();
      if (ce_pix && de) begin
        chk($sformatf("pix%0d", p), 32'(pix_rgba), 32'(ref_img[p[7:0]]));
        p++;
      end
    end
    ce_pix = 1'b0; de = 1'b0;
    chk("pix_count", 32'(p), 32'd24);

    // Starve the FIFO: 8 buffered pixels then one underrun
    repeat (30) tick();
    chk("underrun_pre", 32'(underrun), 32'd0);
    ack_stall = 1;
    pop_check(8);
    chk("underrun_before_starve", 32'(underrun), 32'd0);
    ce_pix = 1'b1; de = 1'b1;
    tick();
    ce_pix = 1'b0; de = 1'b0;
    chk("starved_pix", 32'(pix_rgba), 32'd0);
    chk("underrun_set", 32'(underrun), 32'd1);

    // Frame restart with the stalled read still in flight
    chk("rd_inflight", 32'(mem_req & mem_rnw), 32'd1);
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    ack_stall = 0;
    n = 0;
    while (mem_req && n < 50) begin tick(); n++; end
    chk("old_rd_done", 32'(mem_req), 32'd0);
    n = 0;
    while (!mem_req && n < 50) begin tick(); n++; end
    chk("vs_next_req", 32'(mem_req), 32'd1);
    chk("vs_next_addr", 32'(mem_addr), 32'd0);
    chk("vs_next_rnw", 32'(mem_rnw), 32'd1);
    repeat (30) tick();
    p = 0;
    pop_check(4);
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // Reset in the middle of a read, then a stale ack
    repeat (10) tick();
    ack_stall = 1;
    pop_check(2);
    n = 0;
    while (!(mem_req && mem_rnw) && n < 50) begin tick(); n++; end
    chk("rd_before_rst", 32'(mem_req & mem_rnw), 32'd1);
    reset_n = 1'b0;
    #3;
    check_reset_vals("midrst");
    tick(); tick();
    reset_n = 1'b1;
    ack_stall = 0; inject_ack = 1;
    tick(); tick();
    chk("stale_req", 32'(mem_req), 32'd0);
    chk("stale_bg_valid", 32'(bg_valid), 32'd0);
    chk("stale_dl_wait", 32'(dl_wait), 32'd0);
    chk("stale_wlog", 32'(wlog.size()), 32'(wexp.size()));

    // Recovery write, then rom_dl invalidates the background
    dl_active = 1'b1; ack_delay = 1;
    tick();
    chk("bg_valid_reset", 32'(bg_valid), 32'd1);
    send_word(24'd5, 16'($urandom));
    wait_writes();
    rom_dl = 1'b1; tick(); rom_dl = 1'b0;
    chk("rom_dl_clear", 32'(bg_valid), 32'd0);
    dl_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce_pix = 1'b1; de = 1'b1;
      tick();
      chk($sformatf("inval_pix%0d", i), 32'(pix_rgba), 32'd0);
      chk($sformatf("inval_req%0d", i), 32'(mem_req), 32'd0);
    end
    ce_pix = 1'b0; de = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
